// File: rtl/ysyx_23060208_idu_pkg.sv
// Shared types and constants for the IDU issue stage.
// Opcodes, bus widths and the register-usage bundle.
package ysyx_23060208_idu_pkg;

  localparam int XLEN = 32;
  localparam int RLEN = 5;

  localparam int IFU_TO_IDU_BUS = 2 * XLEN;
  localparam int ISSUE_BUS      = 2 * XLEN + RLEN + 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic uses_rd;
  } reg_usage_t;

endpackage

// File: rtl/ysyx_23060208_reg_usage.sv
// Combinational register-usage classifier.
// Maps opcode/funct3 to which of rs1, rs2, rd an instruction touches.
module ysyx_23060208_reg_usage
  import ysyx_23060208_idu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  output reg_usage_t usage_o
);

  logic csr_any;
  logic csr_reg;

  // funct3 000/100 are ecall/ebreak/mret or reserved
  assign csr_any = funct3_i[1:0] != 2'b00;
  assign csr_reg = csr_any && !funct3_i[2];

  always_comb begin
    usage_o = '0;
    unique case (1'b1)
      (opcode_i == OP_R): begin
        usage_o.uses_rs1 = 1'b1;
        usage_o.uses_rs2 = 1'b1;
        usage_o.uses_rd  = 1'b1;
      end
      (opcode_i == OP_IMM),
      (opcode_i == OP_LOAD),
      (opcode_i == OP_JALR): begin
        usage_o.uses_rs1 = 1'b1;
        usage_o.uses_rd  = 1'b1;
      end
      (opcode_i == OP_STORE),
      (opcode_i == OP_BRANCH): begin
        usage_o.uses_rs1 = 1'b1;
        usage_o.uses_rs2 = 1'b1;
      end
      (opcode_i == OP_JAL),
      (opcode_i == OP_LUI),
      (opcode_i == OP_AUIPC): begin
        usage_o.uses_rd = 1'b1;
      end
      (opcode_i == OP_SYSTEM): begin
        usage_o.uses_rs1 = csr_reg;
        usage_o.uses_rd  = csr_any;
      end
      default: begin
        usage_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_23060208_idu_issue.sv
// IDU issue stage: instruction queue, RAW scoreboard, hazard hold.
// YSYX_23060208_SB_WB_BYPASS_EN lets a same-cycle writeback free a source.
module ysyx_23060208_idu_issue
  import ysyx_23060208_idu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 5,
  parameter int IQ_DEPTH   = 4,
  parameter int SB_CNT_W   = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [2*DATA_WIDTH-1:0]           ifu_to_idu_bus,
  input  logic                              ifu_to_idu_valid,
  output logic                              idu_allowin,
  output logic [2*DATA_WIDTH+REG_WIDTH:0]   issue_bus,
  output logic                              idu_to_exu_valid,
  input  logic                              exu_allowin,
  input  logic                              wb_valid,
  input  logic [REG_WIDTH-1:0]              wb_rd,
  output logic                              sb_err,
  output logic [$clog2(IQ_DEPTH):0]         iq_count
);

  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 1 << REG_WIDTH;
  localparam int BUS_W = 2 * DATA_WIDTH;

  localparam logic [SB_CNT_W-1:0] SB_MAX = '1;
  localparam logic [SB_CNT_W-1:0] SB_ONE = SB_CNT_W'(1);

  logic [BUS_W-1:0]    iq_q [IQ_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SB_CNT_W-1:0] sb_q [NREG];
  logic [SB_CNT_W-1:0] sb_d [NREG];
  logic                err_q, err_d;

  logic [NREG-1:0]     inc_v, dec_v;

  logic                empty, full;
  logic                push, fire, hazard;
  logic [BUS_W-1:0]    head;
  logic [DATA_WIDTH-1:0] head_pc, head_inst;
  logic [REG_WIDTH-1:0]  rs1, rs2, rd;
  logic [SB_CNT_W-1:0] rs1_cnt, rs2_cnt, rd_cnt;
  logic                rs1_busy, rs2_busy, rd_sat;
  logic                byp1, byp2;
  logic                writes_rd;
  reg_usage_t          usage;

  assign empty = cnt_q == '0;
  assign full  = cnt_q == CNT_W'(IQ_DEPTH);

  assign head      = iq_q[rd_ptr_q];
  assign head_pc   = head[BUS_W-1:DATA_WIDTH];
  assign head_inst = head[DATA_WIDTH-1:0];

  assign rd  = head_inst[7  +: REG_WIDTH];
  assign rs1 = head_inst[15 +: REG_WIDTH];
  assign rs2 = head_inst[20 +: REG_WIDTH];

  ysyx_23060208_reg_usage u_usage (
    .opcode_i (head_inst[6:0]),
    .funct3_i (head_inst[14:12]),
    .usage_o  (usage)
  );

  assign rs1_cnt = sb_q[rs1];
  assign rs2_cnt = sb_q[rs2];
  assign rd_cnt  = sb_q[rd];

`ifdef YSYX_23060208_SB_WB_BYPASS_EN
  // last outstanding write retiring now frees the source this cycle
  assign byp1 = wb_valid && (wb_rd == rs1) && (rs1_cnt == SB_ONE);
  assign byp2 = wb_valid && (wb_rd == rs2) && (rs2_cnt == SB_ONE);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign writes_rd = usage.uses_rd && (rd != '0);

  assign rs1_busy = usage.uses_rs1 && (rs1 != '0)
                 && (rs1_cnt != '0) && !byp1;
  assign rs2_busy = usage.uses_rs2 && (rs2 != '0)
                 && (rs2_cnt != '0) && !byp2;
  assign rd_sat   = writes_rd && (rd_cnt == SB_MAX);

  assign hazard = rs1_busy || rs2_busy || rd_sat;

  assign idu_allowin      = !full;
  assign idu_to_exu_valid = !empty && !hazard && !flush;

  assign push = ifu_to_idu_valid && idu_allowin && !flush;
  assign fire = idu_to_exu_valid && exu_allowin;

  assign issue_bus = empty ? '0
                   : {head_pc, head_inst, rd, writes_rd};

  assign sb_err   = err_q;
  assign iq_count = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, fire})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int i = 1; i < NREG; i++) begin
      inc_v[i] = fire && writes_rd
              && (rd == REG_WIDTH'(i));
      dec_v[i] = wb_valid && (wb_rd == REG_WIDTH'(i))
              && (sb_q[i] != '0);
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      sb_d[i] = sb_q[i];
      unique case ({inc_v[i], dec_v[i]})
        2'b10:   sb_d[i] = sb_q[i] + SB_ONE;
        2'b01:   sb_d[i] = sb_q[i] - SB_ONE;
        default: sb_d[i] = sb_q[i];
      endcase
    end
    err_d = err_q;
    if (wb_valid && (wb_rd != '0) && (sb_q[wb_rd] == '0))
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < NREG; i++) sb_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      for (int i = 0; i < NREG; i++) sb_q[i] <= sb_d[i];
    end
  end

  // payload storage needs no reset; occupancy gates its visibility
  always_ff @(posedge clk) begin
    if (push) iq_q[wr_ptr_q] <= ifu_to_idu_bus;
  end

endmodule

// File: tb/tb_ysyx_23060208_idu_issue.sv
// Directed bench for ysyx_23060208_idu_issue.
// Per-cycle vector table plus reset-during-stall sequence.
module tb_ysyx_23060208_idu_issue;

`ifdef YSYX_23060208_SB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [63:0] ifu_to_idu_bus;
  logic        ifu_to_idu_valid;
  logic        idu_allowin;
  logic [69:0] issue_bus;
  logic        idu_to_exu_valid;
  logic        exu_allowin;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        sb_err;
  logic [2:0]  iq_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_23060208_idu_issue dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .ifu_to_idu_bus   (ifu_to_idu_bus),
    .ifu_to_idu_valid (ifu_to_idu_valid),
    .idu_allowin      (idu_allowin),
    .issue_bus        (issue_bus),
    .idu_to_exu_valid (idu_to_exu_valid),
    .exu_allowin      (exu_allowin),
    .wb_valid         (wb_valid),
    .wb_rd            (wb_rd),
    .sb_err           (sb_err),
    .iq_count         (iq_count)
  );

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ea;
    logic        wv;
    logic [4:0]  wr;
    logic        fl;
    logic        ev;
    logic        eal;
    logic [2:0]  ecnt;
    logic        eerr;
    logic [31:0] epc;
  } vec_t;

  vec_t vq[$];

  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'b0010011};
  endfunction

  function automatic logic [31:0] add(int rd, int rs1, int rs2);
    return {7'b0, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] lui(int rd, int imm);
    return {imm[19:0], rd[4:0], 7'b0110111};
  endfunction

  function automatic vec_t mk(bit iv, int pc, logic [31:0] inst,
                              bit ea, bit wv, int wr, bit fl,
                              bit ev, bit eal, int ecnt,
                              bit eerr, int epc);
    vec_t v;
    v.iv = iv;   v.pc = pc;   v.inst = inst;
    v.ea = ea;   v.wv = wv;   v.wr = wr[4:0];
    v.fl = fl;   v.ev = ev;   v.eal = eal;
    v.ecnt = ecnt[2:0];
    v.eerr = eerr;
    v.epc = epc;
    return v;
  endfunction

  task automatic chk(string name, logic [71:0] act, logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    ifu_to_idu_valid = 1'b0;
    ifu_to_idu_bus   = '0;
    exu_allowin      = 1'b0;
    wb_valid         = 1'b0;
    wb_rd            = '0;
    flush            = 1'b0;
  endtask

  task automatic push_inst(int pc, logic [31:0] inst);
    ifu_to_idu_valid = 1'b1;
    ifu_to_idu_bus   = {pc[31:0], inst};
  endtask

  initial begin
    int n1;
    int n0;
    n1 = BYP ? 0 : 1;
    n0 = BYP ? 1 : 0;

    // fill to full, reject while full, drain in order
    vq.push_back(mk(1,'h100,addi(11,0,1),0,0,0,0, 0,1,0,0,0));
    vq.push_back(mk(1,'h104,addi(12,0,2),0,0,0,0, 1,1,1,0,'h100));
    vq.push_back(mk(1,'h108,addi(13,0,3),0,0,0,0, 1,1,2,0,'h100));
    vq.push_back(mk(1,'h10c,addi(14,0,4),0,0,0,0, 1,1,3,0,'h100));
    vq.push_back(mk(0,0,0,0,0,0,0,                1,0,4,0,'h100));
    vq.push_back(mk(1,'h200,addi(15,0,5),1,0,0,0, 1,0,4,0,'h100));
    vq.push_back(mk(0,0,0,1,0,0,0,                1,1,3,0,'h104));
    vq.push_back(mk(0,0,0,1,0,0,0,                1,1,2,0,'h108));
    vq.push_back(mk(0,0,0,1,0,0,0,                1,1,1,0,'h10c));
    vq.push_back(mk(0,0,0,1,0,0,0,                0,1,0,0,0));
    // RAW on x5
    vq.push_back(mk(1,'h300,addi(5,0,5),1,0,0,0,  0,1,0,0,0));
    vq.push_back(mk(1,'h304,add(6,5,1),1,0,0,0,   1,1,1,0,'h300));
    vq.push_back(mk(0,0,0,1,0,0,0,                0,1,1,0,0));
    vq.push_back(mk(0,0,0,1,0,0,0,                0,1,1,0,0));
    vq.push_back(mk(0,0,0,1,1,5,0,                BYP,1,1,0,'h304));
    vq.push_back(mk(0,0,0,1,0,0,0,                !BYP,1,n1,0,'h304));
    vq.push_back(mk(0,0,0,1,0,0,0,                0,1,0,0,0));
    // x0 writers, then ecall while x3 pending
    vq.push_back(mk(1,'h400,addi(0,0,1),1,0,0,0,  0,1,0,0,0));
    vq.push_back(mk(1,'h404,lui(0,'h12345),1,0,0,0, 1,1,1,0,'h400));
    vq.push_back(mk(1,'h408,addi(3,0,3),1,0,0,0,  1,1,1,0,'h404));
    vq.push_back(mk(1,'h40c,32'h73,1,0,0,0,       1,1,1,0,'h408));
    vq.push_back(mk(0,0,0,1,0,0,0,                1,1,1,0,'h40c));
    // x7 counter saturation
    vq.push_back(mk(1,'h500,addi(7,0,1),1,0,0,0,  0,1,0,0,0));
    vq.push_back(mk(1,'h504,addi(7,0,2),1,0,0,0,  1,1,1,0,'h500));
    vq.push_back(mk(1,'h508,addi(7,0,3),1,0,0,0,  1,1,1,0,'h504));
    vq.push_back(mk(1,'h50c,addi(7,0,4),1,0,0,0,  1,1,1,0,'h508));
    vq.push_back(mk(0,0,0,1,0,0,0,                0,1,1,0,0));
    vq.push_back(mk(0,0,0,1,0,0,0,                0,1,1,0,0));
    vq.push_back(mk(0,0,0,1,1,7,0,                0,1,1,0,0));
    vq.push_back(mk(0,0,0,1,0,0,0,                1,1,1,0,'h50c));
    vq.push_back(mk(0,0,0,1,0,0,0,                0,1,0,0,0));
    // inc and dec of x9 together, then underflow on x10
    vq.push_back(mk(1,'h600,addi(9,0,1),1,0,0,0,  0,1,0,0,0));
    vq.push_back(mk(1,'h604,addi(9,0,2),1,0,0,0,  1,1,1,0,'h600));
    vq.push_back(mk(1,'h608,add(22,9,0),1,1,9,0,  1,1,1,0,'h604));
    vq.push_back(mk(0,0,0,1,0,0,0,                0,1,1,0,0));
    vq.push_back(mk(0,0,0,1,1,9,0,                BYP,1,1,0,'h608));
    vq.push_back(mk(0,0,0,1,0,0,0,                !BYP,1,n1,0,'h608));
    vq.push_back(mk(0,0,0,1,1,10,0,               0,1,0,0,0));
    vq.push_back(mk(0,0,0,1,0,0,0,                0,1,0,1,0));
    // flush with 3 queued and a push offered
    vq.push_back(mk(1,'h700,addi(0,0,1),0,0,0,0,  0,1,0,1,0));
    vq.push_back(mk(1,'h704,addi(0,0,2),0,0,0,0,  1,1,1,1,'h700));
    vq.push_back(mk(1,'h708,addi(0,0,3),0,0,0,0,  1,1,2,1,'h700));
    vq.push_back(mk(1,'h70c,addi(0,0,4),0,0,0,1,  0,1,3,1,0));
    vq.push_back(mk(0,0,0,1,0,0,0,                0,1,0,1,0));
    // x22 still pending after flush
    vq.push_back(mk(1,'h800,add(23,22,0),1,0,0,0, 0,1,0,1,0));
    vq.push_back(mk(0,0,0,1,0,0,0,                0,1,1,1,0));
    vq.push_back(mk(0,0,0,1,1,22,0,               BYP,1,1,1,'h800));
    vq.push_back(mk(0,0,0,1,0,0,0,                !BYP,1,n1,1,'h800));
    vq.push_back(mk(0,0,0,1,0,0,0,                0,1,0,1,0));

    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst valid", 72'(idu_to_exu_valid), 72'(0));
    chk("rst allowin", 72'(idu_allowin), 72'(1));
    chk("rst count", 72'(iq_count), 72'(0));
    chk("rst err", 72'(sb_err), 72'(0));
    chk("rst bus", 72'(issue_bus), 72'(0));
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      ifu_to_idu_valid = vq[i].iv;
      ifu_to_idu_bus   = {vq[i].pc, vq[i].inst};
      exu_allowin      = vq[i].ea;
      wb_valid         = vq[i].wv;
      wb_rd            = vq[i].wr;
      flush            = vq[i].fl;
      #1;
      chk($sformatf("v%0d valid", i),
          72'(idu_to_exu_valid), 72'(vq[i].ev));
      chk($sformatf("v%0d allowin", i),
          72'(idu_allowin), 72'(vq[i].eal));
      chk($sformatf("v%0d count", i),
          72'(iq_count), 72'(vq[i].ecnt));
      chk($sformatf("v%0d err", i),
          72'(sb_err), 72'(vq[i].eerr));
      if (vq[i].ev)
        chk($sformatf("v%0d pc", i),
            72'(issue_bus[69:38]), 72'(vq[i].epc));
    end

    // reset while stalled on x24
    @(negedge clk);
    idle();
    exu_allowin = 1'b1;
    push_inst('h900, addi(24,0,1));
    @(negedge clk);
    push_inst('h904, add(25,24,0));
    #1;
    chk("rs head pc", 72'(issue_bus[69:38]), 72'('h900));
    chk("rs head wr", 72'(issue_bus[5:0]), 72'({5'd24, 1'b1}));
    @(negedge clk);
    ifu_to_idu_valid = 1'b0;
    #1;
    chk("rs stall", 72'(idu_to_exu_valid), 72'(0));
    chk("rs stall cnt", 72'(iq_count), 72'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rs2 count", 72'(iq_count), 72'(0));
    chk("rs2 valid", 72'(idu_to_exu_valid), 72'(0));
    chk("rs2 allowin", 72'(idu_allowin), 72'(1));
    chk("rs2 err", 72'(sb_err), 72'(0));
    push_inst('h908, add(25,24,0));
    @(negedge clk);
    ifu_to_idu_valid = 1'b0;
    #1;
    chk("rs3 valid", 72'(idu_to_exu_valid), 72'(1));
    chk("rs3 pc", 72'(issue_bus[69:38]), 72'('h908));
    @(negedge clk);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_23060208_idu_issue.md
Name: ysyx_23060208_idu_issue

Overview:
Decode-side issue stage placed between IFU and the full decoder/EXU. Buffers fetched {pc, inst} pairs in a parametrised instruction queue. Classifies each head instruction's register usage and tracks in-flight register writes in a per-register scoreboard. Holds the head instruction until its RAW hazards resolve, replacing the single-register, no-hazard-check IDU front end.

Parameters:
- DATA_WIDTH, 32, pc/inst width
- REG_WIDTH, 5, register index width; scoreboard has 2**REG_WIDTH entries
- IQ_DEPTH, 4, instruction queue entries; power of two, >=2
- SB_CNT_W, 2, width of each per-register pending-write counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all queued instructions
- ifu_to_idu_bus  in  2*DATA_WIDTH  {pc, inst}
- ifu_to_idu_valid  in  1  IFU entry valid
- idu_allowin  out  1  queue can accept
- issue_bus  out  2*DATA_WIDTH+REG_WIDTH+1  {pc, inst, rd, writes_rd}
- idu_to_exu_valid  out  1  head issuable
- exu_allowin  in  1  downstream accepts
- wb_valid  in  1  a register write retires this cycle
- wb_rd  in  REG_WIDTH  retiring destination register
- sb_err  out  1  sticky: writeback to a register with zero pending count
- iq_count  out  $clog2(IQ_DEPTH)+1  current occupancy

Behaviour:
- Single clock clk; rst is synchronous, active-high. The reset/handshake/timing rules in this section are fixed.
- Reset values:
  - queue empty, pointers 0, all counters 0
  - idu_to_exu_valid=0, idu_allowin=1, sb_err=0, iq_count=0
- Enqueue:
  - idu_allowin = (iq_count != IQ_DEPTH); it does not depend on exu_allowin.
  - push = ifu_to_idu_valid && idu_allowin && !flush.
  - The entry is visible at the head the cycle after the push (minimum latency 1).
- Register-usage classification of the head (combinational):
  - 0110011: rs1, rs2, rd
  - 0010011, 0000011, 1100111: rs1, rd
  - 0100011, 1100011: rs1, rs2
  - 1101111, 0110111, 0010111: rd
  - 1110011 with funct3 001/010/011: rs1, rd
  - 1110011 with funct3 101/110/111: rd
  - ecall, ebreak, mret, unknown opcodes: none
  - writes_rd = uses_rd && rd != 0. Register x0 is never a hazard source.
- Hazard:
  - hazard = (uses_rs1 && rs1!=0 && cnt[rs1]!=0) || (uses_rs2 && rs2!=0 && cnt[rs2]!=0) || (writes_rd && cnt[rd]==max).
  - idu_to_exu_valid = !empty && !hazard && !flush.
  - issue_bus is driven from the head entry whenever the queue is non-empty, otherwise 0.
- Issue:
  - fire = idu_to_exu_valid && exu_allowin; fire pops the head.
  - Push and pop in the same cycle leave iq_count unchanged. Pointers wrap modulo IQ_DEPTH.
- Scoreboard update, same cycle:
  - fire && writes_rd: cnt[rd] += 1
  - wb_valid && wb_rd!=0: cnt[wb_rd] -= 1
  - Both on the same register: count unchanged.
  - wb_valid to a register whose count is 0: counter stays 0, sb_err set until rst.
  - wb_rd==0 is ignored.
  - Without the optional feature, a decrement is visible to the hazard check the next cycle.
- Flush:
  - Next cycle the queue is empty and the pointers return to 0.
  - No push or issue occurs in the flush cycle.
  - The scoreboard is not cleared; in-flight instructions still write back.
- rst during a stall or partial fill returns everything to reset values on the next edge.

Optional Feature:
- Macro: YSYX_23060208_SB_WB_BYPASS_EN.
- When defined: a source register counts as free in the same cycle if wb_valid && wb_rd==src && cnt[src]==1. The head issues in the writeback cycle.
- When undefined: issue occurs no earlier than the cycle after the writeback.

Decomposition:
- Shared package ysyx_23060208_idu_pkg holds:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM)
  - IFU_TO_IDU_BUS and ISSUE_BUS width constants
  - a reg_usage_t struct {uses_rs1, uses_rs2, uses_rd}
- One natural sub-module: ysyx_23060208_reg_usage, the combinational inst -> reg_usage_t classifier, reused later by the forwarding unit.

Test Plan:
- Fill and drain:
  - Stimulus: push 4 addi with exu_allowin=0.
  - Response: iq_count=4, idu_allowin=0. Raise exu_allowin: 4 issues in consecutive cycles, pc order preserved, wrap of pointers checked.
- RAW stall:
  - Stimulus: issue addi x5; queue add x6,x5,x1.
  - Response: idu_to_exu_valid=0 until wb_valid with wb_rd=5. It rises 1 cycle after the wb, or in the wb cycle with bypass enabled.
- x0 and no-source instructions:
  - Stimulus: issue addi x0,x0,1, then lui x0; then issue ecall while cnt[x3]=1.
  - Response: no counter change, no stall, ecall issues.
- Saturation:
  - Stimulus: SB_CNT_W=2; issue 3 writers of x7 without writeback; a 4th writer of x7 is at the head.
  - Response: it stalls until one wb to x7.
- Simultaneous inc/dec and underflow:
  - Stimulus: fire a writer of x9 while wb_rd=9 and cnt[9]=1.
  - Response: cnt[9] stays 1. Then send wb to x10 with cnt=0: sb_err=1 and it stays 1.
- Flush:
  - Stimulus: with 3 entries queued, assert flush together with ifu_to_idu_valid=1.
  - Response: next cycle iq_count=0, idu_to_exu_valid=0, the incoming entry is dropped, scoreboard counts unchanged.
